xor4_parity_checker: RTL and testbench

- Receive side of the XOr4xN parity scheme.
- Each word arrives as four N-bit lanes (I0..I3) plus an N-bit parity field P, where P[k] = I0[k]^I1[k]^I2[k]^I3[k] (even parity per bit column).
- The block recomputes the parity, flags mismatches per column, forwards the data through one registered valid/ready stage, and keeps a saturating error counter plus a sticky error flag for host/status logic.

---
 rtl/xor_parity_pkg.sv | 15 +
 rtl/xor4_parity_if.sv | 25 ++
 rtl/xor4_syndrome.sv | 20 ++
 rtl/xor4_parity_checker.sv | 111 +++++++++++
 tb/tb_xor4_parity_checker.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/xor_parity_pkg.sv
// Shared constants and the per-column parity function for the XOr4xN parity scheme.
// Used by both the generator side and the receive-side checker.
package xor_parity_pkg;

  localparam int LANE_W_DEFAULT = 2;
  localparam int NUM_LANES      = 4;
  localparam int CNT_W_DEFAULT  = 8;

  // One parity column: XOR of the four lane bits and the parity bit.
  // Zero means the column carries even parity.
  function automatic logic parity_col(input logic [NUM_LANES-1:0] lane_bits, input logic p_bit);
    return (^lane_bits) ^ p_bit;
  endfunction

endpackage

// File: rtl/xor4_parity_if.sv
// Data and handshake bundle of the parity checker: input word with valid/ready,
// and the registered output word with syndrome and valid/ready.
interface xor4_parity_if
  import xor_parity_pkg::*;
#(
  parameter int N = LANE_W_DEFAULT
);
  logic [N-1:0] I0, I1, I2, I3, P;
  logic         I_VALID;
  logic         I_READY;
  logic [N-1:0] O0, O1, O2, O3, O_SYND;
  logic         O_ERR;
  logic         O_VALID;
  logic         O_READY;

  modport master (
    output I0, I1, I2, I3, P, I_VALID, O_READY,
    input  I_READY, O0, O1, O2, O3, O_SYND, O_ERR, O_VALID
  );

  modport slave (
    input  I0, I1, I2, I3, P, I_VALID, O_READY,
    output I_READY, O0, O1, O2, O3, O_SYND, O_ERR, O_VALID
  );
endinterface

// File: rtl/xor4_syndrome.sv
// Combinational N-column syndrome of four lanes plus parity; with p_i tied to 0
// the same block produces the parity field on the generator side.
module xor4_syndrome
  import xor_parity_pkg::*;
#(
  parameter int N = LANE_W_DEFAULT
) (
  input  logic [N-1:0] i0_i,
  input  logic [N-1:0] i1_i,
  input  logic [N-1:0] i2_i,
  input  logic [N-1:0] i3_i,
  input  logic [N-1:0] p_i,
  output logic [N-1:0] synd_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_col
    assign synd_o[gi] = parity_col({i3_i[gi], i2_i[gi], i1_i[gi], i0_i[gi]}, p_i[gi]);
  end

endmodule

// File: rtl/xor4_parity_checker.sv
// Receive-side parity checker: one registered valid/ready stage, saturating error
// counter and sticky flag. Define DROP_BAD_EN to discard words with a parity error.
module xor4_parity_checker
  import xor_parity_pkg::*;
#(
  parameter int N     = LANE_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  xor4_parity_if.slave     bus,
  input  logic             CLR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             STICKY
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     synd;
  logic             bad_word;
  logic             accept;
  logic             load;

  logic [N-1:0]     lane_in [NUM_LANES];
  logic [N-1:0]     lane_q  [NUM_LANES];
  logic [N-1:0]     lane_d  [NUM_LANES];
  logic [N-1:0]     synd_q, synd_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             sticky_q, sticky_d;

  xor4_syndrome #(.N(N)) u_synd (
    .i0_i   (bus.I0),
    .i1_i   (bus.I1),
    .i2_i   (bus.I2),
    .i3_i   (bus.I3),
    .p_i    (bus.P),
    .synd_o (synd)
  );

  assign lane_in[0] = bus.I0;
  assign lane_in[1] = bus.I1;
  assign lane_in[2] = bus.I2;
  assign lane_in[3] = bus.I3;

  assign bad_word    = |synd;
  assign bus.I_READY = !valid_q || bus.O_READY;
  assign accept      = bus.I_VALID && bus.I_READY;

`ifdef DROP_BAD_EN
  // Erroneous words are still counted but never reach the output stage.
  assign load = accept && !bad_word;
`else
  assign load = accept;
`endif

  always_comb begin
    lane_d  = lane_q;
    synd_d  = synd_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (load) begin
      lane_d  = lane_in;
      synd_d  = synd;
      err_d   = bad_word;
      valid_d = 1'b1;
    end else if (bus.O_READY) begin
      valid_d = 1'b0;
    end
  end

  // Clear is applied before the current word's error, so CLR+error gives 1.
  always_comb begin
    cnt_base = CLR ? '0 : cnt_q;
    cnt_d    = cnt_base;
    sticky_d = (CLR ? 1'b0 : sticky_q) | (accept && bad_word);
    if (accept && bad_word && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lane_q   <= '{default: '0};
      synd_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      synd_q   <= synd_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.O0      = lane_q[0];
  assign bus.O1      = lane_q[1];
  assign bus.O2      = lane_q[2];
  assign bus.O3      = lane_q[3];
  assign bus.O_SYND  = synd_q;
  assign bus.O_ERR   = err_q;
  assign bus.O_VALID = valid_q;
  assign ERR_CNT     = cnt_q;
  assign STICKY      = sticky_q;

endmodule

// File: tb/tb_xor4_parity_checker.sv
// Directed bench for xor4_parity_checker (N=2, CNT_W=2); expectations follow
// DROP_BAD_EN when the macro is defined for the build.
module tb_xor4_parity_checker;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CLR;
  logic [1:0] ERR_CNT;
  logic       STICKY;
  int         checks = 0;
  int         errors = 0;

  xor4_parity_if #(.N(2)) bus ();

  xor4_parity_checker #(.N(2), .CNT_W(2)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .CLR     (CLR),
    .ERR_CNT (ERR_CNT),
    .STICKY  (STICKY)
  );

  always #5 CLK = ~CLK;

  // Clean words, lanes packed {I0,I1,I2,I3}, with hand-computed parity.
  localparam logic [7:0] W_A = 8'b00_01_10_11; localparam logic [1:0] P_A = 2'b00;
  localparam logic [7:0] W_B = 8'b11_01_00_01; localparam logic [1:0] P_B = 2'b11;
  localparam logic [7:0] W_C = 8'b10_10_01_00; localparam logic [1:0] P_C = 2'b01;
  localparam logic [7:0] W_D = 8'b01_11_11_10; localparam logic [1:0] P_D = 2'b11;
  localparam logic [7:0] W_T = 8'b01_10_11_00; // lanes of the plan's example word

`ifdef DROP_BAD_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_word(input logic [7:0] w, input logic [1:0] p, input logic v);
    bus.I0 = w[7:6];
    bus.I1 = w[5:4];
    bus.I2 = w[3:2];
    bus.I3 = w[1:0];
    bus.P  = p;
    bus.I_VALID = v;
  endtask

  function automatic logic [7:0] out_lanes();
    return {bus.O0, bus.O1, bus.O2, bus.O3};
  endfunction

  task automatic test_reset();
    RESET = 1'b1; CLR = 1'b0; bus.O_READY = 1'b1;
    set_word(8'h00, 2'b00, 1'b0);
    repeat (3) step();
    RESET = 1'b0;
    step();
    checks++;
    if ({bus.O_VALID, bus.O_ERR, STICKY, bus.I_READY} !== 4'b0001) begin
      errors++; $display("FAIL reset_flags got %b exp 0001", {bus.O_VALID, bus.O_ERR, STICKY, bus.I_READY});
    end
    checks++;
    if ({out_lanes(), bus.O_SYND} !== 10'd0) begin
      errors++; $display("FAIL reset_data got %h exp 000", {out_lanes(), bus.O_SYND});
    end
    checks++;
    if (ERR_CNT !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ERR_CNT); end
  endtask

  task automatic test_clean();
    set_word(W_T, 2'b00, 1'b1);
    step();
    set_word(W_T, 2'b00, 1'b0);
    $display("clean word lanes=%b out=%b synd=%b", W_T, out_lanes(), bus.O_SYND);
    checks++;
    if (bus.O_VALID !== 1'b1) begin errors++; $display("FAIL clean_valid got %b exp 1", bus.O_VALID); end
    checks++;
    if (out_lanes() !== W_T) begin errors++; $display("FAIL clean_lanes got %b exp %b", out_lanes(), W_T); end
    checks++;
    if ({bus.O_SYND, bus.O_ERR, ERR_CNT, STICKY} !== 6'b00_0_00_0) begin
      errors++; $display("FAIL clean_status got %b exp 000000", {bus.O_SYND, bus.O_ERR, ERR_CNT, STICKY});
    end
    step();
    checks++;
    if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL clean_drain got %b exp 0", bus.O_VALID); end
  endtask

  task automatic test_bad();
    set_word(W_T, 2'b01, 1'b1);
    step();
    set_word(W_T, 2'b00, 1'b0);
    $display("bad word lanes=%b p=01 valid=%b synd=%b cnt=%0d", W_T, bus.O_VALID, bus.O_SYND, ERR_CNT);
    checks++;
    if ({ERR_CNT, STICKY} !== 3'b01_1) begin errors++; $display("FAIL bad_cnt got %b exp 011", {ERR_CNT, STICKY}); end
    checks++;
    if (DROP) begin
      if (bus.O_VALID !== 1'b0) begin errors++; $display("FAIL bad_drop_valid got %b exp 0", bus.O_VALID); end
    end else begin
      if ({bus.O_VALID, bus.O_SYND, bus.O_ERR} !== 4'b1_01_1) begin
        errors++; $display("FAIL bad_fwd got %b exp 1011", {bus.O_VALID, bus.O_SYND, bus.O_ERR});
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w_seq [3];
    logic [1:0] p_seq [3];
    w_seq = '{W_B, W_C, W_D};
    p_seq = '{P_B, P_C, P_D};
    bus.O_READY = 1'b0;
    set_word(W_A, P_A, 1'b1);
    step();
    set_word(W_B, P_B, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.O_VALID, bus.I_READY, out_lanes()} !== {2'b10, W_A}) begin
        errors++; $display("FAIL stall_hold%0d got %b exp %b", i, {bus.O_VALID, bus.I_READY, out_lanes()}, {2'b10, W_A});
      end
      step();
    end
    bus.O_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(w_seq[i], p_seq[i], 1'b1);
      step();
      $display("b2b word %0d out=%b valid=%b", i, out_lanes(), bus.O_VALID);
      checks++;
      if ({bus.O_VALID, out_lanes()} !== {1'b1, w_seq[i]}) begin
        errors++; $display("FAIL b2b_word%0d got %b exp %b", i, {bus.O_VALID, out_lanes()}, {1'b1, w_seq[i]});
      end
    end
    set_word(W_A, P_A, 1'b0);
    step();
    checks++;
    if ({bus.O_VALID, ERR_CNT} !== 3'b0_01) begin
      errors++; $display("FAIL b2b_end got %b exp 001", {bus.O_VALID, ERR_CNT});
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    checks++;
    if ({ERR_CNT, STICKY} !== 3'b00_0) begin errors++; $display("FAIL clr_only got %b exp 000", {ERR_CNT, STICKY}); end
    for (int i = 0; i < 5; i++) begin
      set_word(W_A, 2'b10, 1'b1);
      step();
      $display("sat word %0d cnt=%0d", i, ERR_CNT);
      checks++;
      if (ERR_CNT !== exp_cnt[i]) begin errors++; $display("FAIL sat%0d got %0d exp %0d", i, ERR_CNT, exp_cnt[i]); end
    end
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    set_word(W_A, P_A, 1'b0);
    checks++;
    if ({ERR_CNT, STICKY} !== 3'b01_1) begin errors++; $display("FAIL clr_err got %b exp 011", {ERR_CNT, STICKY}); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.O_READY = 1'b0;
    set_word(W_A, 2'b10, 1'b1);
    step();
    set_word(W_A, P_A, 1'b1);
    step();
    set_word(W_A, P_A, 1'b0);
    checks++;
    if ({bus.O_VALID, ERR_CNT} !== 3'b1_10) begin
      errors++; $display("FAIL pre_reset got %b exp 110", {bus.O_VALID, ERR_CNT});
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++;
    if ({bus.O_VALID, ERR_CNT, STICKY, bus.I_READY} !== 5'b0_00_0_1) begin
      errors++; $display("FAIL mid_reset got %b exp 00001", {bus.O_VALID, ERR_CNT, STICKY, bus.I_READY});
    end
    checks++;
    if ({out_lanes(), bus.O_SYND} !== 10'd0) begin
      errors++; $display("FAIL mid_reset_data got %h exp 000", {out_lanes(), bus.O_SYND});
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bad();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
